restoring_divider8: RTL
=======================

RESTORING_DIVIDER8 -- requirements
Module: restoring_divider8

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port Start, input, 1 bit: a divide request, sampled only in IDLE.
REQ-004 The block SHALL have the port Dividend, input, 8 bits: an unsigned dividend, captured on the Start edge.
REQ-005 The block SHALL have the port Divisor, input, 8 bits: an unsigned divisor, captured on the Start edge.
REQ-006 The block SHALL have the port Quotient, output, 8 bits: the result, held stable from Done until the next accepted Start.
REQ-007 The block SHALL have the port Remainder, output, 8 bits: the result, held stable under the same rule as Quotient.
REQ-008 The block SHALL have the port Busy, output, 1 bit: high while state is not IDLE.
REQ-009 The block SHALL have the port Done, output, 1 bit: a one-cycle pulse when results are valid.
REQ-010 The block SHALL have the port DivErr, output, 1 bit: the divide-by-zero flag, valid with Done (see Configuration).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE SHALL go to RUN on the rising edge where Start=1; on that edge operands SHALL be latched, the 9-bit partial remainder SHALL clear to 0 and the iteration counter SHALL load 0.
REQ-013 Each RUN cycle SHALL perform one restoring step:
- shift {R, Q} left by 1, bringing in the Q MSB as the R LSB;
- trial subtract R - Divisor in 9 bits;
- if there is no borrow, keep the difference and set Q[0]=1;
- otherwise restore R and set Q[0]=0.
REQ-014 RUN SHALL last exactly 8 cycles (counter 0..7), then go to DONE.
REQ-015 Done SHALL be high only in DONE, exactly 9 clock edges after the accepting Start edge.
REQ-016 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-017 Start asserted during RUN or DONE SHALL be ignored, with no queuing.
REQ-018 Start held high continuously SHALL start a new divide on the first IDLE cycle, i.e. one operation per 10 cycles.
REQ-019 Changes on Dividend and Divisor after the Start edge SHALL NOT affect the operation in progress.
REQ-020 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder and Remainder < Divisor for every nonzero Divisor.
REQ-021 Quotient and Remainder SHALL update only on the edge entering DONE; in IDLE they SHALL retain the last values.

Reset
REQ-022 Reset_n=0 SHALL immediately force the following, independent of Clk:
- state to IDLE;
- Quotient, Remainder and the internal registers to 0;
- the counter to 0;
- Busy, Done and DivErr to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no Done pulse SHALL follow release.
REQ-024 After release, the first rising edge with Start=1 SHALL be accepted normally.

Configuration
REQ-025 The block SHALL use the macro DIVIDER_DBZ_EN.
REQ-026 With DIVIDER_DBZ_EN defined:
- Divisor=0 at Start SHALL go IDLE to DONE directly, with Done 1 edge after Start;
- the block SHALL output Quotient=8'hFF, Remainder=Dividend and DivErr=1 for that Done cycle.
REQ-027 Without DIVIDER_DBZ_EN:
- DivErr SHALL be tied 0;
- Divisor=0 SHALL run the normal 8-cycle algorithm, yielding Quotient=8'hFF and Remainder=Dividend.

Structure
REQ-028 Package div_pkg SHALL hold the following:
- the state enum type (IDLE, RUN, DONE);
- parameter DIV_W=8;
- parameter DIV_ITER=8.
REQ-029 The trial subtraction SHALL be a combinational sub-module subtractor9, with 9-bit inputs A and B, 9-bit output Diff and output Borrow.
REQ-030 The FSM, the counter and the shift registers SHALL live in restoring_divider8.

Verification
REQ-031 The bench SHALL cover: Dividend=200, Divisor=7 -> Quotient=28, Remainder=4, Done at edge 9, Busy high on edges 1..9.
REQ-032 The bench SHALL cover: Dividend=255, Divisor=1 -> Quotient=255, Remainder=0; then Dividend=5, Divisor=9 -> Quotient=0, Remainder=5.
REQ-033 The bench SHALL cover Dividend=100, Divisor=0:
- with the macro -> Done at edge 1, Quotient=FF, Remainder=100, DivErr=1;
- without the macro -> Done at edge 9, Quotient=FF, Remainder=100, DivErr=0.
REQ-034 The bench SHALL cover: pulse Start and change operands during RUN -> no restart, and the original result is produced.
REQ-035 The bench SHALL cover: assert Reset_n low at RUN cycle 4 -> all outputs go 0 immediately and no Done follows; then 9/3 -> Quotient=3, Remainder=0.
REQ-036 The bench SHALL cover: an exhaustive 65536-pair sweep checked against the REQ-020 identity.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the 8-bit restoring divider.
package div_pkg;

    localparam int DIV_W    = 8;
    localparam int DIV_ITER = 8;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/restoring_divider8_subtractor9.sv
// Combinational 9-bit trial subtractor; Borrow is set when A < B.
module subtractor9 (
    input  logic [8:0] A,
    input  logic [8:0] B,
    output logic [8:0] Diff,
    output logic       Borrow
);

    assign {Borrow, Diff} = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/restoring_divider8.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per cycle.
// Define DIVIDER_DBZ_EN to short-cut divide-by-zero straight to DONE with DivErr.
module restoring_divider8
    import div_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [DIV_W-1:0] Dividend,
    input  logic [DIV_W-1:0] Divisor,
    output logic [DIV_W-1:0] Quotient,
    output logic [DIV_W-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivErr,
    output div_state_e       DbgState
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W:0]    r_q, r_d;
    logic [DIV_W-1:0]  q_q, q_d;
    logic [DIV_W-1:0]  dvs_q, dvs_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [DIV_W-1:0]  rem_q, rem_d;

    logic [DIV_W:0]    r_shift;
    logic [DIV_W-1:0]  q_shift;
    logic [DIV_W:0]    sub_diff;
    logic              sub_borrow;
    logic [DIV_W:0]    r_step;
    logic [DIV_W-1:0]  q_step;

    // {R, Q} shifted left as one register pair; the dropped R MSB is always 0.
    assign r_shift = (DIV_W+1)'({r_q, q_q[DIV_W-1]});
    assign q_shift = {q_q[DIV_W-2:0], 1'b0};

    subtractor9 u_sub (
        .A      (r_shift),
        .B      ({1'b0, dvs_q}),
        .Diff   (sub_diff),
        .Borrow (sub_borrow)
    );

    assign r_step = sub_borrow ? r_shift : sub_diff;
    assign q_step = {q_shift[DIV_W-1:1], ~sub_borrow};

`ifdef DIVIDER_DBZ_EN
    logic dbz_q, dbz_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIVIDER_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    dvs_d   = Divisor;
                    q_d     = Dividend;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIVIDER_DBZ_EN
                    dbz_d   = 1'b0;
                    if (Divisor == '0) begin
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = Dividend;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    quo_d   = q_step;
                    rem_d   = r_step[DIV_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIVIDER_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
    assign DbgState  = state_q;

`ifdef DIVIDER_DBZ_EN
    assign DivErr = (state_q == DONE) && dbz_q;
`else
    assign DivErr = 1'b0;
`endif

endmodule
